cfi_shadow_stack_ctrl: RTL

- Return-address shadow-stack controller attached to the CVA6 commit stage, alongside the existing CFI return-landing checker.
- Watches every committing call and return across all commit ports, in program order.
- Shares one circular shadow stack between the ports: calls push, returns pop.
- A return is a violation when its resolved target differs from the popped value; it is also a violation when it pops an empty stack that has no lost entries.
- Violations are counted, reported with their PC and port, and escalate to a sticky alarm.

---
 rtl/cfi_pkg.sv | 29 ++
 rtl/cfi_ras_buffer.sv | 119 +++++++++++
 rtl/cfi_shadow_stack_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cfi_pkg.sv
// Shared types for the commit-stage return-address shadow stack.
// Stack-op bundle, FSM state and return-address helper.
package cfi_pkg;

  localparam int unsigned CFI_VLEN = 64;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } cfi_state_e;

  typedef struct packed {
    logic                valid;
    logic                push;
    logic                pop;
    logic [CFI_VLEN-1:0] push_val;
    logic [CFI_VLEN-1:0] target;
    logic [CFI_VLEN-1:0] pc;
  } cfi_stack_op_t;

  function automatic logic [CFI_VLEN-1:0] cfi_ret_addr(
    input logic [CFI_VLEN-1:0] pc,
    input logic                compressed
  );
    return pc + (compressed ? CFI_VLEN'(2) : CFI_VLEN'(4));
  endfunction

endpackage

// File: rtl/cfi_ras_buffer.sv
// Circular return-address stack shared by all commit ports.
// Ops apply in port order; later ports see earlier ports' effects.
module cfi_ras_buffer
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned CNT_W           = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH+1)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  cfi_stack_op_t [NR_COMMIT_PORTS-1:0]       op_i,
  output logic [NR_COMMIT_PORTS-1:0]                pop_hit_o,
  output logic [NR_COMMIT_PORTS-1:0]                pop_empty_o,
  output logic [NR_COMMIT_PORTS-1:0][CFI_VLEN-1:0]  pop_val_o,
  output logic [CW-1:0]                             count_o
);

  logic [CFI_VLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]    lost_q, lost_d;

  logic [NR_COMMIT_PORTS-1:0]               we;
  logic [NR_COMMIT_PORTS-1:0][PW-1:0]       waddr;
  logic [NR_COMMIT_PORTS-1:0][CFI_VLEN-1:0] wdata;

  logic unused_ok;

  // Chain each port's pop-then-push through pointer, count and lost count.
  always_comb begin
    logic [PW-1:0] rd;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    pop_hit_o   = '0;
    pop_empty_o = '0;
    pop_val_o   = '0;
    rd          = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (op_i[p].valid && op_i[p].pop) begin
        if (cnt_d != '0) begin
          rd           = ptr_d - PW'(1);
          pop_hit_o[p] = 1'b1;
          pop_val_o[p] = mem_q[rd];
          for (int q = 0; q < p; q++) begin
            if (we[q] && waddr[q] == rd) begin
              pop_val_o[p] = wdata[q];
            end
          end
          ptr_d = rd;
          cnt_d = cnt_d - CW'(1);
        end else if (lost_d != '0) begin
          lost_d = lost_d - CNT_W'(1);
        end else begin
          pop_empty_o[p] = 1'b1;
        end
      end
      if (op_i[p].valid && op_i[p].push) begin
        we[p]    = 1'b1;
        waddr[p] = ptr_d;
        wdata[p] = op_i[p].push_val;
        ptr_d    = ptr_d + PW'(1);
        if (cnt_d == CW'(DEPTH)) begin
          if (lost_d != '1) begin
            lost_d = lost_d + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_d + CW'(1);
        end
      end
    end
    if (flush_i) begin
      ptr_d  = '0;
      cnt_d  = '0;
      lost_d = '0;
      we     = '0;
    end
  end

  // Target and pc travel with the op but are only checked upstream.
  always_comb begin
    unused_ok = 1'b0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      unused_ok = unused_ok ^ (^{op_i[p].target, op_i[p].pc});
    end
  end

  // Stack bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      lost_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      lost_q <= lost_d;
    end
  end

  // Entry storage; the youngest port wins on a same-slot write.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (we[p]) begin
        mem_q[waddr[p]] <= wdata[p];
      end
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/cfi_shadow_stack_ctrl.sv
// Shadow-stack controller watching committed calls and returns.
// Flags mismatched or underflowing returns and raises a sticky alarm.
module cfi_shadow_stack_ctrl
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned VLEN            = 64,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned ALARM_THRESHOLD = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               clear_i,
  input  logic [NR_COMMIT_PORTS-1:0]         commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]         commit_call_i,
  input  logic [NR_COMMIT_PORTS-1:0]         commit_ret_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0]    commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0]         commit_compressed_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0]    commit_target_i,
  output logic                               violation_o,
  output logic [$clog2(NR_COMMIT_PORTS)-1:0] violation_port_o,
  output logic [VLEN-1:0]                    violation_pc_o,
  output logic [CNT_W-1:0]                   violation_cnt_o,
  output logic                               alarm_o,
  output logic [$clog2(DEPTH+1)-1:0]         depth_o
);

  localparam int unsigned PORT_W = $clog2(NR_COMMIT_PORTS);
  localparam int unsigned NUM_W  = $clog2(NR_COMMIT_PORTS+1);

  cfi_state_e state_q, state_d;
  logic       active, flush;

  cfi_stack_op_t [NR_COMMIT_PORTS-1:0]       ops;
  logic [NR_COMMIT_PORTS-1:0]                pop_hit, pop_empty, viol;
  logic [NR_COMMIT_PORTS-1:0][CFI_VLEN-1:0]  pop_val;

  logic [PORT_W-1:0] vport;
  logic [VLEN-1:0]   vpc;
  logic [NUM_W-1:0]  vnum;
  logic [CNT_W:0]    vsum;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;

  // Next state, stack activity and flush control.
  always_comb begin
    state_d = state_q;
    active  = 1'b0;
    flush   = 1'b0;
    if (clear_i) begin
      flush   = 1'b1;
      state_d = enable_i ? RUN : OFF;
    end else begin
      unique case (state_q)
        OFF: begin
          flush = 1'b1;
          if (enable_i) state_d = RUN;
        end
        RUN: begin
          if (cnt_q >= CNT_W'(ALARM_THRESHOLD)) begin
            state_d = ALARM;
            active  = 1'b1;
          end else if (!enable_i) begin
            state_d = OFF;
            flush   = 1'b1;
          end else begin
            active = 1'b1;
          end
        end
        ALARM: active = 1'b1;
        default: begin
          state_d = OFF;
          flush   = 1'b1;
        end
      endcase
    end
  end

  // Bundle each commit port into a stack op.
  always_comb begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      ops[p].valid    = active & commit_valid_i[p];
      ops[p].push     = commit_call_i[p];
      ops[p].pop      = commit_ret_i[p];
      ops[p].pc       = commit_pc_i[p*VLEN +: VLEN];
      ops[p].target   = commit_target_i[p*VLEN +: VLEN];
      ops[p].push_val = cfi_ret_addr(ops[p].pc, commit_compressed_i[p]);
    end
  end

  cfi_ras_buffer #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .DEPTH           (DEPTH),
    .CNT_W           (CNT_W)
  ) i_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush),
    .op_i        (ops),
    .pop_hit_o   (pop_hit),
    .pop_empty_o (pop_empty),
    .pop_val_o   (pop_val),
    .count_o     (depth_o)
  );

  // Per-port check, oldest violator and saturating count update.
  always_comb begin
    vport = '0;
    vpc   = '0;
    vnum  = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      viol[p] = ops[p].valid & ops[p].pop &
                (pop_empty[p] |
                 (pop_hit[p] & (pop_val[p] != ops[p].target)));
      vnum = vnum + NUM_W'(viol[p]);
    end
    for (int p = NR_COMMIT_PORTS-1; p >= 0; p--) begin
      if (viol[p]) begin
        vport = PORT_W'(p);
        vpc   = ops[p].pc;
      end
    end
    vsum    = {1'b0, cnt_q} + (CNT_W+1)'(vnum);
    cnt_nxt = vsum[CNT_W] ? '1 : vsum[CNT_W-1:0];
  end

  // State and registered violation reporting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= OFF;
      violation_o      <= 1'b0;
      violation_port_o <= '0;
      violation_pc_o   <= '0;
      cnt_q            <= '0;
    end else begin
      state_q     <= state_d;
      violation_o <= |viol;
      if (|viol) begin
        violation_port_o <= vport;
        violation_pc_o   <= vpc;
      end
      cnt_q <= clear_i ? '0 : cnt_nxt;
    end
  end

  assign violation_cnt_o = cnt_q;
  assign alarm_o         = (state_q == ALARM);

endmodule
